// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - parametrised SAP-1 operand register bank with ULA and tri-state bus read ports
//
// DEPTH registers of WIDTH bits plus a carry flag. One register (sel_w) may be
// loaded, shifted or incremented per clock; two independent combinational read
// ports expose registered state to the ULA and to the shared bus.
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   CLR_n       asynchronous active-low clear of all registers and carry
//   Lr          write enable, performs op on regs[sel_w]
//   op          00 LOAD, 01 SHL, 10 SHR, 11 INC
//   sel_w       index of the register written or modified
//   entrada     bus data, used by LOAD only
//   sel_ula     index of the register driven to para_ula
//   para_ula    regs[sel_ula], always driven (0 when sel_ula is out of range)
//   zero_ula    1 when para_ula is zero
//   Er          bus output enable
//   sel_bus     index of the register driven to barramento
//   barramento  regs[sel_bus] when Er = 1, otherwise high-Z
//   carry       carry / shift-out flag register

`timescale 1ns/1ps

module banco_registradores #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             Lr,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    sel_w,
    input  logic [WIDTH-1:0] entrada,
    input  logic [AW-1:0]    sel_ula,
    output logic [WIDTH-1:0] para_ula,
    output logic             zero_ula,
    input  logic             Er,
    input  logic [AW-1:0]    sel_bus,
    output logic [WIDTH-1:0] barramento,
    output logic             carry
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [DEPTH];
    logic             c_q;

    logic [WIDTH-1:0] ula_val;
    logic [WIDTH-1:0] bus_val;
    logic [WIDTH-1:0] cur_val;
    logic             sel_w_ok;
    logic [WIDTH-1:0] nxt_val;
    logic             nxt_c;
    logic             wr_en;

    // Read muxes built as compare-and-select loops so that select codes with
    // no backing register (non power-of-two DEPTH) fall through to zero, and
    // so the write path learns whether sel_w names a real register.
    always_comb begin
        ula_val  = '0;
        bus_val  = '0;
        cur_val  = '0;
        sel_w_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_ula == AW'(i)) begin
                ula_val = regs[i];
            end
            if (sel_bus == AW'(i)) begin
                bus_val = regs[i];
            end
            if (sel_w == AW'(i)) begin
                cur_val  = regs[i];
                sel_w_ok = 1'b1;
            end
        end
    end

    // Next value of the selected register and of the carry flag.
    always_comb begin
        nxt_val = cur_val;
        nxt_c   = c_q;
        case (op)
            OP_LOAD: begin
                nxt_val = entrada;
            end
            OP_SHL: begin
                nxt_val = {cur_val[WIDTH-2:0], 1'b0};
                nxt_c   = cur_val[WIDTH-1];
            end
            OP_SHR: begin
                nxt_val = {1'b0, cur_val[WIDTH-1:1]};
                nxt_c   = cur_val[0];
            end
            OP_INC: begin
                nxt_val = cur_val + ONE;
                nxt_c   = &cur_val;
            end
            default: begin
                nxt_val = cur_val;
                nxt_c   = c_q;
            end
        endcase
    end

    // An out-of-range sel_w must leave the carry untouched as well as the
    // registers, so the flag update shares the same qualified enable.
    assign wr_en = Lr & sel_w_ok;

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            c_q <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_w == AW'(i)) begin
                    regs[i] <= nxt_val;
                end
            end
            c_q <= nxt_c;
        end
    end

    assign para_ula   = ula_val;
    assign zero_ula   = (ula_val == '0);
    assign barramento = Er ? bus_val : {WIDTH{1'bz}};
    assign carry      = c_q;

endmodule

// File: tb/tb_banco_registradores.sv
// tb/tb_banco_registradores.sv - self-checking bench for banco_registradores (8x4 and 4x3 builds)

`timescale 1ns/1ps

module tb_banco_registradores;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic CLR_n;

    logic       lr8, er8, z8, c8;
    logic [1:0] op8, sw8, su8, sb8;
    logic [7:0] ent8, pu8, bus8;

    logic       lr4, er4, z4, c4;
    logic [1:0] op4, sw4, su4, sb4;
    logic [3:0] ent4, pu4, bus4;

    banco_registradores #(.WIDTH(8), .DEPTH(4)) dut8 (
        .CLK(CLK), .CLR_n(CLR_n), .Lr(lr8), .op(op8), .sel_w(sw8),
        .entrada(ent8), .sel_ula(su8), .para_ula(pu8), .zero_ula(z8),
        .Er(er8), .sel_bus(sb8), .barramento(bus8), .carry(c8)
    );

    banco_registradores #(.WIDTH(4), .DEPTH(3)) dut4 (
        .CLK(CLK), .CLR_n(CLR_n), .Lr(lr4), .op(op4), .sel_w(sw4),
        .entrada(ent4), .sel_ula(su4), .para_ula(pu4), .zero_ula(z4),
        .Er(er4), .sel_bus(sb4), .barramento(bus4), .carry(c4)
    );

    int tests = 0;
    int fails = 0;

    int m8 [4];
    int mc8;
    int m4 [3];
    int mc4;

    logic [7:0] zz8 = 8'bzzzzzzzz;
    logic [3:0] zz4 = 4'bzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour on plain integers: registers are numbers mod 2^w.
    task automatic model(input int w, input int opc, input int v, input int d, input int cin,
                         output int nv, output int nc);
        int full;
        full = 1 << w;
        nv = v;
        nc = cin;
        case (opc)
            0: nv = d % full;
            1: begin nv = (v * 2) % full; nc = (v >= full / 2) ? 1 : 0; end
            2: begin nv = v / 2;          nc = v % 2;                    end
            default: begin nv = (v + 1) % full; nc = (v == full - 1) ? 1 : 0; end
        endcase
    endtask

    task automatic reset_models();
        for (int i = 0; i < 4; i++) m8[i] = 0;
        for (int i = 0; i < 3; i++) m4[i] = 0;
        mc8 = 0;
        mc4 = 0;
    endtask

    task automatic step8(input logic lr, input int opc, input int sel, input int d);
        int nv, nc;
        @(negedge CLK);
        lr8 = lr; op8 = opc[1:0]; sw8 = sel[1:0]; ent8 = d[7:0];
        @(posedge CLK); #1;
        if (lr) begin
            model(8, opc, m8[sel], d, mc8, nv, nc);
            m8[sel] = nv;
            mc8 = nc;
        end
        lr8 = 1'b0;
    endtask

    task automatic step4(input logic lr, input int opc, input int sel, input int d);
        int nv, nc;
        @(negedge CLK);
        lr4 = lr; op4 = opc[1:0]; sw4 = sel[1:0]; ent4 = d[3:0];
        @(posedge CLK); #1;
        if (lr && sel < 3) begin
            model(4, opc, m4[sel], d, mc4, nv, nc);
            m4[sel] = nv;
            mc4 = nc;
        end
        lr4 = 1'b0;
    endtask

    task automatic check8(input string tag);
        er8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            su8 = i[1:0]; sb8 = i[1:0];
            #1;
            chk($sformatf("%s_ula%0d", tag, i), pu8, m8[i]);
            chk($sformatf("%s_bus%0d", tag, i), bus8, m8[i]);
            chk($sformatf("%s_zero%0d", tag, i), z8, (m8[i] == 0) ? 1 : 0);
        end
        chk($sformatf("%s_carry", tag), c8, mc8);
    endtask

    task automatic check4(input string tag);
        er4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            su4 = i[1:0]; sb4 = i[1:0];
            #1;
            chk($sformatf("%s_ula%0d", tag, i), pu4, m4[i]);
            chk($sformatf("%s_bus%0d", tag, i), bus4, m4[i]);
            chk($sformatf("%s_zero%0d", tag, i), z4, (m4[i] == 0) ? 1 : 0);
        end
        chk($sformatf("%s_carry", tag), c4, mc4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a write attempted on both builds: reset must win.
        CLR_n = 1'b0;
        lr8 = 1'b1; op8 = 2'b00; sw8 = 2'd1; ent8 = 8'hFF; su8 = 2'd1; sb8 = 2'd1; er8 = 1'b1;
        lr4 = 1'b1; op4 = 2'b11; sw4 = 2'd0; ent4 = 4'hF; su4 = 2'd0; sb4 = 2'd0; er4 = 1'b1;
        reset_models();
        #2;
        chk("rst_ula", pu8, 8'h00);
        chk("rst_bus", bus8, 8'h00);
        chk("rst_zero", z8, 1'b1);
        chk("rst_carry", c8, 1'b0);
        er8 = 1'b0;
        #1;
        chk("rst_bus_z", bus8, zz8);
        @(posedge CLK); #1;
        check8("rst_edge8");
        check4("rst_edge4");
        @(negedge CLK);
        lr8 = 1'b0; lr4 = 1'b0;
        CLR_n = 1'b1;

        // Load and independent reads.
        step8(1'b1, 0, 1, 8'h3C);
        step8(1'b1, 0, 2, 8'hA5);
        su8 = 2'd1; sb8 = 2'd2; er8 = 1'b1;
        #1;
        chk("load_ula_r1", pu8, 8'h3C);
        chk("load_bus_r2", bus8, 8'hA5);
        chk("load_zero", z8, 1'b0);
        check8("load");

        // Shift and carry on r1.
        step8(1'b1, 0, 1, 8'h81);
        step8(1'b1, 1, 1, 0);
        su8 = 2'd1; #1;
        chk("shl_val", pu8, 8'h02);
        chk("shl_c", c8, 1'b1);
        step8(1'b1, 2, 1, 0);
        su8 = 2'd1; #1;
        chk("shr1_val", pu8, 8'h01);
        chk("shr1_c", c8, 1'b0);
        step8(1'b1, 2, 1, 0);
        su8 = 2'd1; #1;
        chk("shr2_val", pu8, 8'h00);
        chk("shr2_c", c8, 1'b1);
        chk("shr2_zero", z8, 1'b1);
        step8(1'b1, 0, 1, 8'h10);
        chk("load_keeps_c", c8, 1'b1);
        check8("shift");

        // Increment wrap, then clear mid-count.
        step8(1'b1, 0, 3, 8'hFE);
        step8(1'b1, 3, 3, 0);
        su8 = 2'd3; #1;
        chk("inc_ff", pu8, 8'hFF);
        chk("inc_ff_c", c8, 1'b0);
        step8(1'b1, 3, 3, 0);
        su8 = 2'd3; #1;
        chk("inc_wrap", pu8, 8'h00);
        chk("inc_wrap_c", c8, 1'b1);
        step8(1'b1, 3, 3, 0);
        step8(1'b1, 3, 3, 0);
        su8 = 2'd3; #1;
        chk("inc_two", pu8, 8'h02);
        CLR_n = 1'b0;
        #1;
        chk("midrst_val", pu8, 8'h00);
        chk("midrst_c", c8, 1'b0);
        CLR_n = 1'b1;
        reset_models();
        step8(1'b1, 3, 3, 0);
        su8 = 2'd3; #1;
        chk("inc_after_rst", pu8, 8'h01);
        check8("midrst");

        // Same-cycle read/write: old value until the edge.
        @(negedge CLK);
        su8 = 2'd0; lr8 = 1'b1; op8 = 2'b00; sw8 = 2'd0; ent8 = 8'h55;
        #1;
        chk("rw_before", pu8, m8[0]);
        @(posedge CLK); #1;
        lr8 = 1'b0;
        m8[0] = 8'h55;
        chk("rw_after", pu8, 8'h55);

        // Hold with Lr = 0 while op and sel_w toggle.
        for (int k = 0; k < 10; k++) begin
            step8(1'b0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
        end
        check8("hold");

        // Randomised traffic on the 8x4 build.
        for (int k = 0; k < 150; k++) begin
            step8(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 255));
            check8($sformatf("rnd8_%0d", k));
        end

        // 4x3 build: out-of-range selects and INC wrap.
        step4(1'b1, 0, 0, 4'h7);
        step4(1'b1, 0, 1, 4'h9);
        step4(1'b1, 0, 2, 4'hF);
        step4(1'b1, 3, 2, 0);
        su4 = 2'd2; #1;
        chk("w4_inc_wrap", pu4, 4'h0);
        chk("w4_inc_c", c4, 1'b1);
        step4(1'b1, 0, 3, 4'h5);
        step4(1'b1, 2, 3, 0);
        check4("w4_oor_write");
        su4 = 2'd3; sb4 = 2'd3; er4 = 1'b1;
        #1;
        chk("w4_oor_ula", pu4, 4'h0);
        chk("w4_oor_zero", z4, 1'b1);
        chk("w4_oor_bus", bus4, 4'h0);
        er4 = 1'b0;
        #1;
        chk("w4_bus_z", bus4, zz4);
        for (int k = 0; k < 80; k++) begin
            step4(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 15));
            check4($sformatf("rnd4_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
